whack_scorer: RTL and testbench
===============================

WHACK_SCORER -- requirements
Module: whack_scorer

Interface
REQ-001 Parameter ROUND_TICKS, default 20000000, is the count value at which the mole field is redrawn and one round ends.
REQ-002 Parameter NUM_ROUNDS, default 30, is the number of rounds per game.
REQ-003 Parameter MAX_SCORE, default 9999, is the score saturation ceiling.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle pulse requesting a new game.
REQ-007 count  input  28  free-running round tick counter shared with the mole stage.
REQ-008 moles  input  10  lit-mole vector produced by the mole stage.
REQ-009 switch  input  10  synchronised player switches; a toggle in either direction is a whack.
REQ-010 score  output  14  accumulated game score.
REQ-011 last_points  output  8  points awarded by the most recent scoring cycle.
REQ-012 round  output  5  completed-round count of the current game.
REQ-013 hits  output  10  total successful whacks this game.
REQ-014 playing  output  1  high in state PLAY.
REQ-015 game_over  output  1  high in state OVER.

Function
REQ-016 FSM states IDLE, PLAY, OVER; IDLE->PLAY on start; OVER->PLAY on start; PLAY->OVER when round reaches NUM_ROUNDS; start in PLAY ignored.
REQ-017 Entering PLAY clears score, last_points, round, hits on the same edge.
REQ-018 switch_q and moles_q register switch and moles every cycle in all states; no whack is ever scored from a toggle made outside PLAY.
REQ-019 Per lane i: edge[i] = switch[i] != switch_q[i]; hit[i] = edge[i] & moles_q[i]; miss[i] = edge[i] & ~moles_q[i].
REQ-020 Per-hit points pts = ((ROUND_TICKS - count) >> 20) + 1 when count <= ROUND_TICKS, else pts = 1; pts is 1..20 at default parameters.
REQ-021 Cycle gain = popcount(hit) * pts; cycle penalty = popcount(miss); both computed combinationally and applied on the next edge (latency 1 cycle from switch toggle to score update).
REQ-022 score_next = score + gain - penalty, floored at 0 and saturated at MAX_SCORE; gain and penalty in the same cycle net before clamping.
REQ-023 last_points loads gain (saturated to 255) on any cycle with a nonzero edge vector in PLAY; otherwise holds.
REQ-024 hits adds popcount(hit) in PLAY, saturating at 1023.
REQ-025 round increments by 1 on each PLAY cycle where count == ROUND_TICKS; hits in that same cycle score with pts = 1 and are applied in addition to the round increment.
REQ-026 The cycle round becomes NUM_ROUNDS, the FSM enters OVER; whacks in that final cycle are still scored; nothing is scored in OVER.
REQ-027 In IDLE and OVER, score, round, hits, last_points hold their values.
REQ-028 round never exceeds NUM_ROUNDS; 5-bit width requires NUM_ROUNDS <= 31.

Reset
REQ-029 rst asserted at any time, including mid-game, immediately forces state IDLE, score 0, last_points 0, round 0, hits 0, playing 0, game_over 0, switch_q 0, moles_q 0.
REQ-030 After rst release, switch_q captures switch on the first edge, so a switch held high through reset does not register as a whack.

Verification
REQ-031 Reset, start pulse, moles=10'h001 held, count=0, toggle switch[0] -> one cycle later score=20, last_points=20, hits=1.
REQ-032 In PLAY, moles=10'h003, count=10485760, toggle switch[0] and switch[1] same cycle -> score +20, last_points=20, hits +2.
REQ-033 In PLAY with score=0, moles=0, toggle switch[5] -> score stays 0 (floor), last_points=0, hits unchanged.
REQ-034 Score preloaded to 9995 via hits, then hit at count=0 -> score=9999 (saturation).
REQ-035 Drive count==ROUND_TICKS for 30 separate cycles in PLAY -> round=30, game_over=1, playing=0; later toggles leave score unchanged; start pulse -> PLAY with score=0, round=0.
REQ-036 Assert rst mid-game with score=150, round=12 -> all outputs 0, state IDLE asynchronously, before the next clk edge.

Source files
------------

// File: rtl/whack_scorer.sv
// whack_scorer: scoring core for a whack-a-mole game.
//   Watches the player switches against the lit-mole field. Any switch toggle
//   is a whack: on a lit lane it is a hit worth a time-dependent number of
//   points, on a dark lane it costs one point. The core counts completed
//   rounds and ends the game after NUM_ROUNDS of them.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start         single-cycle pulse: begin a new game (from IDLE or OVER)
//   count[27:0]   free-running round tick counter shared with the mole stage
//   moles[9:0]    lit-mole vector
//   switch[9:0]   synchronised player switches
//   score[13:0]   accumulated score, floored at 0, saturated at MAX_SCORE
//   last_points   gain of the most recent cycle that had any whack
//   round[4:0]    completed rounds this game
//   hits[9:0]     successful whacks this game (saturating)
//   playing       high while a game is in progress
//   game_over     high after the final round until the next start
module whack_scorer #(
  parameter int ROUND_TICKS = 20000000,
  parameter int NUM_ROUNDS  = 30,
  parameter int MAX_SCORE   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [27:0] count,
  input  logic [9:0]  moles,
  input  logic [9:0]  switch,
  output logic [13:0] score,
  output logic [7:0]  last_points,
  output logic [4:0]  round,
  output logic [9:0]  hits,
  output logic        playing,
  output logic        game_over
);

  localparam logic [31:0] RT     = 32'(ROUND_TICKS);
  localparam logic [31:0] MAX_SC = 32'(MAX_SCORE);
  localparam logic [4:0]  NR     = 5'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t      state_q, state_d;
  logic [9:0]  switch_q, moles_q;
  logic [13:0] score_q, score_d;
  logic [7:0]  last_points_q, last_points_d;
  logic [4:0]  round_q, round_d;
  logic [9:0]  hits_q, hits_d;

  logic [9:0]  edge_v, hit_v, miss_v;
  logic [31:0] hit_cnt, miss_cnt, pts, gain, total, net, hsum;
  logic [31:0] count_w;

  function automatic logic [31:0] popcnt(input logic [9:0] v);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < 10; i++) c = c + {31'd0, v[i]};
    return c;
  endfunction

  // Datapath: whack detection and point arithmetic, all in 32 bits so the
  // intermediate sums never wrap before clamping.
  always_comb begin
    edge_v   = switch ^ switch_q;
    hit_v    = edge_v & moles_q;
    miss_v   = edge_v & ~moles_q;
    hit_cnt  = popcnt(hit_v);
    miss_cnt = popcnt(miss_v);
    count_w  = {4'd0, count};
    // Earlier in the round is worth more: one extra point per 2^20 ticks left.
    pts      = (count_w <= RT) ? ((RT - count_w) >> 20) + 32'd1 : 32'd1;
    gain     = hit_cnt * pts;
    // Gain and penalty net first, then floor at 0 and cap at MAX_SCORE.
    total    = {18'd0, score_q} + gain;
    if (total <= miss_cnt)  net = 32'd0;
    else                    net = total - miss_cnt;
    if (net > MAX_SC)       net = MAX_SC;
    hsum     = {22'd0, hits_q} + hit_cnt;
    if (hsum > 32'd1023)    hsum = 32'd1023;
  end

  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    last_points_d = last_points_q;
    round_d       = round_q;
    hits_d        = hits_q;
    unique case (state_q)
      IDLE, OVER: begin
        // Whacks outside PLAY are never scored, including on the start edge.
        if (start) begin
          state_d       = PLAY;
          score_d       = 14'd0;
          last_points_d = 8'd0;
          round_d       = 5'd0;
          hits_d        = 10'd0;
        end
      end
      PLAY: begin
        score_d = 14'(net);
        hits_d  = 10'(hsum);
        if (|edge_v) last_points_d = (gain > 32'd255) ? 8'hFF : 8'(gain);
        if (count_w == RT) begin
          round_d = round_q + 5'd1;
          if (round_d == NR) state_d = OVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      switch_q      <= 10'd0;
      moles_q       <= 10'd0;
      score_q       <= 14'd0;
      last_points_q <= 8'd0;
      round_q       <= 5'd0;
      hits_q        <= 10'd0;
    end else begin
      state_q       <= state_d;
      switch_q      <= switch;
      moles_q       <= moles;
      score_q       <= score_d;
      last_points_q <= last_points_d;
      round_q       <= round_d;
      hits_q        <= hits_d;
    end
  end

  assign score       = score_q;
  assign last_points = last_points_q;
  assign round       = round_q;
  assign hits        = hits_q;
  assign playing     = (state_q == PLAY);
  assign game_over   = (state_q == OVER);

endmodule

// File: tb/tb_whack_scorer.sv
module tb_whack_scorer;

  localparam int RT = 20000000;

  logic        clk, rst, start;
  logic [27:0] count;
  logic [9:0]  moles, switch;
  logic [13:0] score;
  logic [7:0]  last_points;
  logic [4:0]  round;
  logic [9:0]  hits;
  logic        playing, game_over;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [9:0] sw_cur;

  typedef struct {
    int    sc, lp, h, rd;
    logic  pl, ov;
    string tag;
  } exp_t;
  exp_t sb[$];

  whack_scorer dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .moles(moles),
    .switch(switch), .score(score), .last_points(last_points), .round(round),
    .hits(hits), .playing(playing), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.tag, ".score"},  32'(score),       32'(e.sc));
    chk({e.tag, ".lp"},     32'(last_points), 32'(e.lp));
    chk({e.tag, ".hits"},   32'(hits),        32'(e.h));
    chk({e.tag, ".round"},  32'(round),       32'(e.rd));
    chk({e.tag, ".play"},   32'(playing),     32'(e.pl));
    chk({e.tag, ".over"},   32'(game_over),   32'(e.ov));
  endtask

  // Drive one cycle of stimulus (toggling the switches in mask), queue the
  // expected post-edge outputs, clock once and compare.
  task automatic tick(input logic [9:0] mask, input logic [9:0] mo,
                      input logic [27:0] cnt, input logic st,
                      input int sc, input int lp, input int h, input int rd,
                      input logic pl, input logic ov, input string tag);
    exp_t e;
    sw_cur = sw_cur ^ mask;
    switch = sw_cur;
    moles  = mo;
    count  = cnt;
    start  = st;
    e = '{sc: sc, lp: lp, h: h, rd: rd, pl: pl, ov: ov, tag: tag};
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    e = sb.pop_front();
    chk_all(e);
  endtask

  initial begin
    exp_t z;
    rst = 1'b1; start = 1'b0; count = '0; moles = '0;
    sw_cur = '0; switch = '0;
    repeat (2) @(posedge clk);
    #1;
    z = '{sc: 0, lp: 0, h: 0, rd: 0, pl: 1'b0, ov: 1'b0, tag: "reset"};
    chk_all(z);
    rst = 1'b0;

    tick(10'h000, 10'h001, 28'd0, 1'b1, 0, 0, 0, 0, 1, 0, "start");
    tick(10'h001, 10'h001, 28'd0, 1'b0, 20, 20, 1, 0, 1, 0, "first_hit");
    // Two hits at count = 10*2^20 -> 10 points each
    tick(10'h000, 10'h003, 28'd10485760, 1'b0, 20, 20, 1, 0, 1, 0, "load_moles3");
    tick(10'h003, 10'h003, 28'd10485760, 1'b0, 40, 20, 3, 0, 1, 0, "double_hit");
    // Misses drain the score to the floor
    tick(10'h000, 10'h000, 28'd0, 1'b0, 40, 20, 3, 0, 1, 0, "load_dark");
    tick(10'h3FF, 10'h000, 28'd0, 1'b0, 30, 0, 3, 0, 1, 0, "miss10_a");
    tick(10'h3FF, 10'h000, 28'd0, 1'b0, 20, 0, 3, 0, 1, 0, "miss10_b");
    tick(10'h3FF, 10'h000, 28'd0, 1'b0, 10, 0, 3, 0, 1, 0, "miss10_c");
    tick(10'h3FF, 10'h000, 28'd0, 1'b0, 0, 0, 3, 0, 1, 0, "miss10_d");
    tick(10'h020, 10'h000, 28'd0, 1'b0, 0, 0, 3, 0, 1, 0, "floor");
    // Hit and miss in the same cycle net before clamping
    tick(10'h000, 10'h001, 28'd0, 1'b0, 0, 0, 3, 0, 1, 0, "load_mole0");
    tick(10'h003, 10'h001, 28'd0, 1'b0, 19, 20, 4, 0, 1, 0, "hit_and_miss");
    tick(10'h001, 10'h001, 28'(RT + 5), 1'b0, 20, 1, 5, 0, 1, 0, "past_round_end");
    tick(10'h001, 10'h001, 28'(RT), 1'b0, 21, 1, 6, 1, 1, 0, "round_edge_hit");
    tick(10'h001, 10'h001, 28'd5319936, 1'b0, 36, 15, 7, 1, 1, 0, "pts15");
    tick(10'h000, 10'h001, 28'd0, 1'b0, 36, 15, 7, 1, 1, 0, "nothing");
    tick(10'h000, 10'h001, 28'd0, 1'b1, 36, 15, 7, 1, 1, 0, "start_in_play");

    // Climb to 9995, then saturate at 9999
    for (int i = 0; i < 497; i++)
      tick(10'h001, 10'h001, 28'd0, 1'b0, 36 + 20 * (i + 1), 20, 8 + i, 1, 1, 0, "climb");
    tick(10'h001, 10'h001, 28'd1125632, 1'b0, 9995, 19, 505, 1, 1, 0, "pts19");
    tick(10'h001, 10'h001, 28'd0, 1'b0, 9999, 20, 506, 1, 1, 0, "saturate");
    tick(10'h001, 10'h001, 28'd0, 1'b0, 9999, 20, 507, 1, 1, 0, "stay_sat");

    // Rounds 2..29, then the final round with a whack still counted
    for (int r = 2; r < 30; r++)
      tick(10'h000, 10'h001, 28'(RT), 1'b0, 9999, 20, 507, r, 1, 0, "round_step");
    tick(10'h001, 10'h001, 28'(RT), 1'b0, 9999, 1, 508, 30, 0, 1, "final_round");
    tick(10'h001, 10'h001, 28'd0, 1'b0, 9999, 1, 508, 30, 0, 1, "over_toggle");
    tick(10'h001, 10'h001, 28'd0, 1'b1, 0, 0, 0, 0, 1, 0, "restart");
    tick(10'h000, 10'h001, 28'd0, 1'b0, 0, 0, 0, 0, 1, 0, "restart_quiet");

    // Build score 150, round 12, then reset asynchronously
    for (int i = 0; i < 7; i++)
      tick(10'h001, 10'h001, 28'd0, 1'b0, 20 * (i + 1), 20, i + 1, 0, 1, 0, "build");
    tick(10'h001, 10'h001, 28'd10485760, 1'b0, 150, 10, 8, 0, 1, 0, "build_10");
    for (int r = 1; r <= 12; r++)
      tick(10'h000, 10'h001, 28'(RT), 1'b0, 150, 10, 8, r, 1, 0, "build_round");
    #2;
    sw_cur = 10'h3FF;
    switch = sw_cur;
    rst = 1'b1;
    #1;
    z = '{sc: 0, lp: 0, h: 0, rd: 0, pl: 1'b0, ov: 1'b0, tag: "async_rst"};
    chk_all(z);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Switches held high through reset must not read as whacks
    tick(10'h000, 10'h001, 28'd0, 1'b1, 0, 0, 0, 0, 1, 0, "post_rst_start");
    tick(10'h000, 10'h001, 28'd0, 1'b0, 0, 0, 0, 0, 1, 0, "post_rst_quiet");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
